// File: rtl/spi_frame_tx.sv
// Serialises a latched snapshot of NCH channel samples as a header word plus
// NCH channel words on mosi/sck/cs, MSB first, with a cs-high gap before each word.
module spi_frame_tx #(
  parameter int DATA_W  = 14,
  parameter int NCH     = 4,
  parameter int SCK_DIV = 4,
  parameter int CS_GAP  = 8,
  parameter logic [DATA_W-1:0] HEADER = 14'h0FFF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_W*NCH-1:0] ch_data,
  output logic                  ready,
  output logic                  done,
  output logic                  hdr_clip,
  output logic                  mosi,
  output logic                  sck,
  output logic                  cs
);

  localparam int HALVES  = 2 * DATA_W;
  localparam int HW      = $clog2(HALVES + 1);
  localparam int CNT_MAX = (CS_GAP > SCK_DIV) ? CS_GAP : SCK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(NCH + 1);

  typedef enum logic [1:0] {IDLE, GAP, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [HW-1:0]           half_q, half_d;
  logic [WW-1:0]           word_q, word_d;
  logic [DATA_W*NCH-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0]       sreg_q, sreg_d;
  logic                    mosi_q, mosi_d;
  logic                    sck_q, sck_d;
  logic                    cs_q, cs_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    clip_q, clip_d;

  logic [DATA_W-1:0]       ch_slice [NCH];
  logic [DATA_W-1:0]       slice_sel;
  logic [DATA_W-1:0]       word_val;
  logic                    clip_cond;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign ch_slice[gi] = ch_q[gi*DATA_W +: DATA_W];
  end

  // Channel words that collide with the header are sent as HEADER-1 so the
  // receiver can always find frame alignment.
  always_comb begin
    slice_sel = '0;
    for (int j = 0; j < NCH; j++) begin
      if (word_q == WW'(j + 1)) slice_sel = ch_slice[j];
    end
    clip_cond = (word_q != '0) && (slice_sel == HEADER);
    if (word_q == '0)   word_val = HEADER;
    else if (clip_cond) word_val = HEADER - DATA_W'(1);
    else                word_val = slice_sel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    word_d  = word_q;
    ch_d    = ch_q;
    sreg_d  = sreg_q;
    mosi_d  = mosi_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    clip_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          state_d = GAP;
          cnt_d   = '0;
          word_d  = '0;
          ch_d    = ch_data;
          ready_d = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q == CW'(CS_GAP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
          cs_d    = 1'b0;
          mosi_d  = word_val[DATA_W-1];
          sreg_d  = {word_val[DATA_W-2:0], 1'b0};
          clip_d  = clip_cond;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != CW'(SCK_DIV - 1)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (half_q == HW'(HALVES)) begin
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            sck_d  = 1'b0;
            if (word_q == WW'(NCH)) begin
              state_d = IDLE;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
              word_d  = word_q + WW'(1);
            end
          end else begin
            half_d = half_q + HW'(1);
            if (!half_q[0]) begin
              sck_d = 1'b1;
            end else begin
              sck_d = 1'b0;
              // The trailing half-period keeps the LSB on mosi.
              if (half_q + HW'(1) != HW'(HALVES)) begin
                mosi_d = sreg_q[DATA_W-1];
                sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      word_q  <= '0;
      ch_q    <= '0;
      sreg_q  <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      word_q  <= word_d;
      ch_q    <= ch_d;
      sreg_q  <= sreg_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      clip_q  <= clip_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign hdr_clip = clip_q;
  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign cs       = cs_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: default instance plus a SCK_DIV=1/CS_GAP=1 instance,
// both decoded by negedge monitors that capture mosi on every sck rise while cs is low.
module tb_spi_frame_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [55:0] ch_data = '0;
  logic        ready, done, hdr_clip, mosi, sck, cs;
  logic        start_c = 1'b0;
  logic [55:0] ch_c = '0;
  logic        ready_c, done_c, clip_c, mosi_c, sck_c, cs_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_frame_tx dut (
    .clk(clk), .rstn(rstn), .start(start), .ch_data(ch_data),
    .ready(ready), .done(done), .hdr_clip(hdr_clip),
    .mosi(mosi), .sck(sck), .cs(cs)
  );

  spi_frame_tx #(.SCK_DIV(1), .CS_GAP(1)) dut_c (
    .clk(clk), .rstn(rstn), .start(start_c), .ch_data(ch_c),
    .ready(ready_c), .done(done_c), .hdr_clip(clip_c),
    .mosi(mosi_c), .sck(sck_c), .cs(cs_c)
  );

  // Monitor for the default instance.
  logic [13:0] sh = '0;
  logic [13:0] words[$];
  logic        sck_p = 1'b0, cs_p = 1'b1;
  int sck_rises = 0, cs_rises = 0, done_n = 0, clip_n = 0, clip_word = -1;
  int gap_cnt = 0, last_gap = -1;
  logic measuring = 1'b0;

  always @(negedge clk) begin
    if (sck && !sck_p && !cs) begin
      sh <= {sh[12:0], mosi};
      sck_rises <= sck_rises + 1;
    end
    if (hdr_clip) begin
      clip_n <= clip_n + 1;
      clip_word <= (!cs && cs_p) ? words.size() : -2;
    end
    if (cs && !cs_p) begin
      words.push_back(sh);
      cs_rises <= cs_rises + 1;
    end
    if (done) begin
      done_n <= done_n + 1;
      measuring <= 1'b1;
      gap_cnt <= 0;
    end else if (measuring) begin
      if (cs) gap_cnt <= gap_cnt + 1;
      else begin
        last_gap <= gap_cnt;
        measuring <= 1'b0;
      end
    end
    sck_p <= sck;
    cs_p  <= cs;
  end

  // Monitor for the corner-parameter instance.
  logic [13:0] sh_c = '0;
  logic [13:0] words_c[$];
  logic        sck_cp = 1'b0, cs_cp = 1'b1;

  always @(negedge clk) begin
    if (sck_c && !sck_cp && !cs_c) sh_c <= {sh_c[12:0], mosi_c};
    if (cs_c && !cs_cp) words_c.push_back(sh_c);
    sck_cp <= sck_c;
    cs_cp  <= cs_c;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input int base, input logic [69:0] exp);
    logic [13:0] e;
    chk({tag, "_count"}, 32'(words.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      e = exp[69 - 14*i -: 14];
      chk($sformatf("%s_w%0d", tag, i), 32'(words[base + i]), 32'(e));
    end
  endtask

  task automatic wait_done(input string tag, input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [55:0] d, output int k);
    @(negedge clk);
    ch_data = d;
    start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
  endtask

  int k, dc, dc2, base, sr0, cr0, dn0, cn0;

  initial begin
    // Reset held with start high: outputs stay at idle values, nothing starts.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cs", 32'(cs), 32'd1);
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_clip", 32'(hdr_clip), 32'd0);
    end
    start = 1'b0;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_cs", 32'(cs), 32'd1);

    // Single frame, with a start pulse mid-frame that must be ignored.
    base = words.size(); sr0 = sck_rises; cr0 = cs_rises; dn0 = done_n; cn0 = clip_n;
    pulse_start({14'h0000, 14'h3FFF, 14'h1234, 14'h0001}, k);
    chk("start_ready", 32'(ready), 32'd0);
    repeat (299) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("single", 1000, dc);
    chk("single_done_at", 32'(dc - k), 32'd620);
    chk("single_done_ready", 32'(ready), 32'd1);
    repeat (200) @(negedge clk);
    check_words("single", base, {14'h0FFF, 14'h0001, 14'h1234, 14'h3FFF, 14'h0000});
    chk("single_cs_rises", 32'(cs_rises - cr0), 32'd5);
    chk("single_sck_rises", 32'(sck_rises - sr0), 32'd70);
    chk("busy_done_count", 32'(done_n - dn0), 32'd1);
    chk("single_no_clip", 32'(clip_n - cn0), 32'd0);
    $display("frame single: %0d words, done at +%0d", words.size() - base, dc - k);

    // Header collision on channel 2.
    base = words.size(); cn0 = clip_n;
    pulse_start({14'h0AAA, 14'h0555, 14'h0FFF, 14'h0123}, k);
    wait_done("clip", 1000, dc);
    repeat (4) @(negedge clk);
    check_words("clip", base, {14'h0FFF, 14'h0123, 14'h0FFE, 14'h0555, 14'h0AAA});
    chk("clip_count", 32'(clip_n - cn0), 32'd1);
    chk("clip_at_word2_csfall", 32'(clip_word), 32'(base + 2));
    $display("frame clip: %0d words, clip at word %0d", words.size() - base, clip_word - base);

    // Back-to-back: start held through the first done cycle.
    base = words.size(); dn0 = done_n;
    @(negedge clk);
    ch_data = {14'h3C3C, 14'h0F0F, 14'h2222, 14'h1111};
    start = 1'b1;
    wait_done("b2b1", 1000, dc);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b2", 1000, dc2);
    repeat (20) @(negedge clk);
    chk("b2b_period", 32'(dc2 - dc), 32'd621);
    // Counted from the cycle after done: the GAP of the second frame.
    chk("b2b_gap", 32'(last_gap), 32'd8);
    chk("b2b_done_count", 32'(done_n - dn0), 32'd2);
    check_words("b2b_f2", base + 5, {14'h0FFF, 14'h1111, 14'h2222, 14'h0F0F, 14'h3C3C});
    $display("frame b2b: %0d words, period %0d", words.size() - base, dc2 - dc);

    // Reset during bit 6 of word 2 (offset 2*124 + 8 + 12*4 = 304).
    pulse_start({14'h1357, 14'h2468, 14'h0ABC, 14'h0DEF}, k);
    while (cyc < k + 305) @(negedge clk);
    chk("mid_cs_low", 32'(cs), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mid_cs", 32'(cs), 32'd1);
    chk("mid_sck", 32'(sck), 32'd0);
    chk("mid_mosi", 32'(mosi), 32'd0);
    chk("mid_ready", 32'(ready), 32'd1);
    dn0 = done_n;
    repeat (700) @(negedge clk);
    chk("mid_no_done", 32'(done_n - dn0), 32'd0);
    base = words.size();
    pulse_start({14'h0001, 14'h0002, 14'h0003, 14'h0004}, k);
    wait_done("after_rst", 1000, dc);
    repeat (4) @(negedge clk);
    chk("after_rst_done_at", 32'(dc - k), 32'd620);
    check_words("after_rst", base, {14'h0FFF, 14'h0004, 14'h0003, 14'h0002, 14'h0001});
    $display("frame after reset: %0d words, done at +%0d", words.size() - base, dc - k);

    // Corner parameters: SCK_DIV=1, CS_GAP=1, W=30, frame 150 cycles.
    base = words_c.size();
    @(negedge clk);
    ch_c = {14'h2AAA, 14'h1555, 14'h0F0F, 14'h3FFE};
    start_c = 1'b1;
    @(negedge clk);
    k = cyc;
    start_c = 1'b0;
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_c) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("corner_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk("corner_done_at", 32'(dc - k), 32'd150);
    chk("corner_count", 32'(words_c.size() - base), 32'd5);
    chk("corner_w0", 32'(words_c[base + 0]), 32'h0FFF);
    chk("corner_w1", 32'(words_c[base + 1]), 32'h3FFE);
    chk("corner_w2", 32'(words_c[base + 2]), 32'h0F0F);
    chk("corner_w3", 32'(words_c[base + 3]), 32'h1555);
    chk("corner_w4", 32'(words_c[base + 4]), 32'h2AAA);
    $display("frame corner: %0d words, done at +%0d", words_c.size() - base, dc - k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
